axi4_burst_master: RTL and testbench

//  Upstream AXI4 master for the memory-mapped slave: converts one simple command (addr, len, rd/wr) plus a

---
 rtl/axi_master_pkg.sv | 45 ++++
 rtl/axi4_burst_master_if.sv | 97 +++++++++
 rtl/axi4_burst_master.sv | 176 +++++++++++++++++
 tb/tb_axi4_burst_master.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_master_pkg.sv
// -----------------------------------------------------------------------------
// axi_master_pkg
// Shared types and constants for the AXI4 burst master:
//   state_e      - controller states (IDLE, AW, W, B, AR, R, RSP)
//   RESP_*       - AXI response encodings
//   BOUNDARY_4K  - AXI bursts must not cross a 4 KB page
//   crosses_4k() - page-crossing test for a beat-aligned INCR burst
//   resp_max()   - worst-case merge of two AXI responses
// -----------------------------------------------------------------------------
package axi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    AR,
    R,
    RSP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int BOUNDARY_4K = 4096;

  // True when a burst starting at page offset 'offset' with AxLEN 'len' and
  // 2**size bytes per beat runs past the end of its 4 KB page. Ending exactly
  // on the boundary is legal.
  function automatic logic crosses_4k(input logic [11:0] offset,
                                      input logic [7:0]  len,
                                      input int          size);
    logic [31:0] span;
    span = ({24'd0, len} + 32'd1) << size;
    return ({20'd0, offset} + span) > 32'(BOUNDARY_4K);
  endfunction

  // Response codes are ordered by severity, so the numerically larger wins.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_burst_master_if.sv
// -----------------------------------------------------------------------------
// axi4_burst_master_if
// Bundles the client side (command, write stream, read stream, response) and
// the AXI4 side (AW/W/B/AR/R) of the burst master.
//   modport master - the burst master's view (drives AXI requests, client data)
//   modport slave  - the environment's view (client + AXI slave)
// -----------------------------------------------------------------------------
interface axi4_burst_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  // client command
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  // client write stream
  logic              wdat_valid;
  logic              wdat_ready;
  logic [DATA_W-1:0] wdat_data;
  // client read stream
  logic              rdat_valid;
  logic              rdat_ready;
  logic [DATA_W-1:0] rdat_data;
  logic              rdat_last;
  // client response
  logic              rsp_valid;
  logic              rsp_write;
  logic [1:0]        rsp_resp;
  logic              rsp_err;
  // AXI write address / data / response
  logic [ADDR_W-1:0] AWADDR;
  logic [7:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  // AXI read address / data
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    input  wdat_valid, wdat_data,
    output wdat_ready,
    output rdat_valid, rdat_data, rdat_last,
    input  rdat_ready,
    output rsp_valid, rsp_write, rsp_resp, rsp_err,
    output AWADDR, AWLEN, AWSIZE, AWVALID,
    input  AWREADY,
    output WDATA, WLAST, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    output wdat_valid, wdat_data,
    input  wdat_ready,
    input  rdat_valid, rdat_data, rdat_last,
    output rdat_ready,
    input  rsp_valid, rsp_write, rsp_resp, rsp_err,
    input  AWADDR, AWLEN, AWSIZE, AWVALID,
    output AWREADY,
    input  WDATA, WLAST, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

endinterface

// File: rtl/axi4_burst_master.sv
// -----------------------------------------------------------------------------
// axi4_burst_master
// Turns one client command (addr, len, rd/wr) plus a data stream into a single
// AXI4 INCR burst and returns one response record. One transaction at a time.
// Ports:
//   ACLK    - clock, rising edge
//   ARESET  - asynchronous active-high reset; abandons any burst in flight
//   bus     - axi4_burst_master_if.master: client cmd/wdat/rdat/rsp + AXI AW/W/B/AR/R
// Data beats are combinational pass-throughs between client and AXI channels
// (W and R states only); the FSM only sequences handshakes and counts beats.
// -----------------------------------------------------------------------------
module axi4_burst_master
  import axi_master_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESET,
  axi4_burst_master_if.master bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int SIZE  = $clog2(BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [7:0]        len_q,   len_d;
  logic              write_q, write_d;
  logic [7:0]        cnt_q,   cnt_d;
  logic [1:0]        resp_q,  resp_d;
  logic              err_q,   err_d;
  // Holds cmd_ready low while reset is asserted and for the first edge after.
  logic              alive_q;

  logic last_beat;
  logic cmd_bad;

  assign last_beat = (cnt_q == len_q);
  assign cmd_bad   = ((bus.cmd_addr & ADDR_W'(BYTES - 1)) != '0) ||
                     crosses_4k(bus.cmd_addr[11:0], bus.cmd_len, SIZE);

  // Address/length come straight from the command registers, so they are
  // stable for the whole AW/AR phase.
  assign bus.AWADDR    = addr_q;
  assign bus.AWLEN     = len_q;
  assign bus.AWSIZE    = 3'(SIZE);
  assign bus.ARADDR    = addr_q;
  assign bus.ARLEN     = len_q;
  assign bus.ARSIZE    = 3'(SIZE);
  assign bus.WDATA     = bus.wdat_data;
  assign bus.WLAST     = last_beat;
  assign bus.rdat_data = bus.RDATA;
  assign bus.rsp_write = write_q;
  assign bus.rsp_resp  = resp_q;
  assign bus.rsp_err   = err_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      resp_q  <= RESP_OKAY;
      err_q   <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      alive_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    err_d   = err_q;

    bus.cmd_ready  = 1'b0;
    bus.AWVALID    = 1'b0;
    bus.WVALID     = 1'b0;
    bus.wdat_ready = 1'b0;
    bus.BREADY     = 1'b0;
    bus.ARVALID    = 1'b0;
    bus.RREADY     = 1'b0;
    bus.rdat_valid = 1'b0;
    bus.rdat_last  = 1'b0;
    bus.rsp_valid  = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.cmd_ready = alive_q;
        if (alive_q && bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          len_d   = bus.cmd_len;
          write_d = bus.cmd_write;
          cnt_d   = '0;
          resp_d  = RESP_OKAY;
          err_d   = 1'b0;
          if (cmd_bad) begin
            // Rejected locally: report straight away, no AXI traffic.
            err_d   = 1'b1;
            resp_d  = RESP_SLVERR;
            state_d = RSP;
          end else begin
            state_d = bus.cmd_write ? AW : AR;
          end
        end
      end

      AW: begin
        bus.AWVALID = 1'b1;
        if (bus.AWREADY) state_d = W;
      end

      W: begin
        bus.WVALID     = bus.wdat_valid;
        bus.wdat_ready = bus.WREADY;
        if (bus.wdat_valid && bus.WREADY) begin
          if (last_beat) state_d = B;
          else           cnt_d   = cnt_q + 8'd1;
        end
      end

      B: begin
        bus.BREADY = 1'b1;
        if (bus.BVALID) begin
          resp_d  = bus.BRESP;
          state_d = RSP;
        end
      end

      AR: begin
        bus.ARVALID = 1'b1;
        if (bus.ARREADY) state_d = R;
      end

      R: begin
        bus.RREADY     = bus.rdat_ready;
        bus.rdat_valid = bus.RVALID;
        bus.rdat_last  = bus.RLAST;
        if (bus.RVALID && bus.rdat_ready) begin
          resp_d = resp_max(resp_q, bus.RRESP);
          if (bus.RLAST) begin
            if (!last_beat) err_d = 1'b1;
            state_d = RSP;
          end else if (last_beat) begin
            // Slave overran the burst: flag it and drain until RLAST.
            // Counter parks at len so it can never wrap.
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      RSP: begin
        bus.rsp_valid = 1'b1;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
module tb_axi4_burst_master;
  import axi_master_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic ACLK   = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  axi4_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  axi4_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  typedef struct {
    bit          write;
    logic [15:0] addr;
    logic [7:0]  len;
    bit          stall;
    int          rlast_at;   // read: beat index carrying RLAST
    logic [1:0]  slv_resp;   // write: BRESP; read: RRESP on beat 1
    logic [31:0] dbase;      // beat i data = dbase + i
    bit          exp_err;
    logic [1:0]  exp_resp;
    bit          exp_axi;
    int          exp_lat;    // accept -> rsp_valid cycles, -1 = not checked
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // slave / client model state
  logic [31:0] mem [0:16383];
  bit          stall;
  int          last_at;
  logic [1:0]  slv_resp;
  logic [31:0] dbase;
  bit          aw_done, aw_wait, ar_wait, b_pend, r_act, rv_hold, wv_hold;
  logic [15:0] aw_addr_h, ar_addr_h, waddr_s, raddr_s;
  logic [7:0]  aw_len_h, ar_len_h;
  int          wlen_s, wcnt_s, rcnt_s;
  int          wn, widx, ridx;
  bit          cmd_pend;
  int          cyc, acc_cyc, rsp_cyc, rsp_cnt;
  logic        rsp_w, rsp_e;
  logic [1:0]  rsp_r;
  int          viol, dmis, lastmis;
  bit          saw_ax;
  logic [15:0] seen_addr;
  logic [7:0]  seen_len;
  logic [2:0]  seen_size;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit go();
    return !stall || ($urandom_range(0, 3) != 0);
  endfunction

  task automatic clear_model();
    b_pend = 0; r_act = 0; aw_wait = 0; ar_wait = 0; rv_hold = 0; wv_hold = 0;
    aw_done = 0; cmd_pend = 0; wn = 0; widx = 0; ridx = 0;
  endtask

  // One clock: drive at the falling edge, observe 1 ns later (before the
  // rising edge), so every recorded handshake is one that fires on that edge.
  task automatic step();
    @(negedge ACLK);
    bus.cmd_valid  = cmd_pend;
    bus.AWREADY    = go();
    bus.WREADY     = go();
    bus.ARREADY    = go();
    bus.BVALID     = b_pend;
    bus.BRESP      = slv_resp;
    if (r_act && (rv_hold || go())) begin
      bus.RVALID = 1'b1;
      bus.RDATA  = mem[int'(raddr_s >> 2) + rcnt_s];
      bus.RRESP  = (rcnt_s == 1) ? slv_resp : RESP_OKAY;
      bus.RLAST  = (rcnt_s == last_at);
    end else begin
      bus.RVALID = 1'b0; bus.RDATA = '0; bus.RRESP = 2'b00; bus.RLAST = 1'b0;
    end
    bus.wdat_valid = (widx < wn) && (wv_hold || go());
    bus.wdat_data  = dbase + 32'(widx);
    bus.rdat_ready = go();
    #1;
    cyc++;

    if (bus.cmd_valid && bus.cmd_ready) begin cmd_pend = 0; acc_cyc = cyc; end
    if (bus.rsp_valid) begin
      rsp_cnt++; rsp_cyc = cyc; rsp_w = bus.rsp_write; rsp_r = bus.rsp_resp; rsp_e = bus.rsp_err;
    end

    if (bus.AWVALID) begin
      saw_ax = 1; seen_addr = bus.AWADDR; seen_len = bus.AWLEN; seen_size = bus.AWSIZE;
      if (aw_wait && (bus.AWADDR !== aw_addr_h || bus.AWLEN !== aw_len_h)) viol++;
      if (bus.AWREADY) begin aw_done = 1; waddr_s = bus.AWADDR; wlen_s = int'(bus.AWLEN); wcnt_s = 0; end
    end else if (aw_wait) viol++;
    aw_wait = bus.AWVALID && !bus.AWREADY; aw_addr_h = bus.AWADDR; aw_len_h = bus.AWLEN;

    if (bus.ARVALID) begin
      saw_ax = 1; seen_addr = bus.ARADDR; seen_len = bus.ARLEN; seen_size = bus.ARSIZE;
      if (ar_wait && (bus.ARADDR !== ar_addr_h || bus.ARLEN !== ar_len_h)) viol++;
      if (bus.ARREADY) begin r_act = 1; raddr_s = bus.ARADDR; rcnt_s = 0; end
    end else if (ar_wait) viol++;
    ar_wait = bus.ARVALID && !bus.ARREADY; ar_addr_h = bus.ARADDR; ar_len_h = bus.ARLEN;

    if (bus.WVALID && !aw_done) viol++;
    if (bus.WVALID && bus.WREADY) begin
      if (bus.WDATA !== dbase + 32'(wcnt_s)) dmis++;
      if (bus.WLAST !== (wcnt_s == wlen_s)) lastmis++;
      mem[int'(waddr_s >> 2) + wcnt_s] = bus.WDATA;
      if (bus.WLAST) b_pend = 1;
      wcnt_s++;
    end
    wv_hold = bus.wdat_valid && !bus.wdat_ready;
    if (bus.wdat_valid && bus.wdat_ready) widx++;
    if (bus.BVALID && bus.BREADY) b_pend = 0;

    rv_hold = bus.RVALID && !bus.RREADY;
    if (bus.RVALID && bus.RREADY) begin
      if (bus.RLAST) r_act = 0;
      rcnt_s++;
    end
    if (bus.rdat_valid && bus.rdat_ready) begin
      if (bus.rdat_data !== dbase + 32'(ridx)) dmis++;
      if (bus.rdat_last !== (ridx == last_at)) lastmis++;
      ridx++;
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int exp_beats;
    stall = v.stall; slv_resp = v.slv_resp; last_at = v.rlast_at; dbase = v.dbase;
    wn = v.write ? int'(v.len) + 1 : 0;
    widx = 0; ridx = 0; dmis = 0; lastmis = 0; viol = 0; saw_ax = 0; aw_done = 0;
    rsp_cnt = 0; rsp_cyc = 0; acc_cyc = 0;
    bus.cmd_write = v.write; bus.cmd_addr = v.addr; bus.cmd_len = v.len;
    cmd_pend = 1;
    for (int k = 0; k < 4000 && rsp_cnt == 0; k++) step();
    step();  // response must be a single-cycle pulse, IDLE right after
    exp_beats = !v.exp_axi ? 0 : (v.write ? int'(v.len) + 1 : v.rlast_at + 1);
    check({tag, ".rsp_pulse"}, rsp_cnt, 1);
    check({tag, ".cmd_ready_after"}, bus.cmd_ready, 1);
    check({tag, ".rsp_write"}, rsp_w, v.write);
    check({tag, ".rsp_resp"}, rsp_r, v.exp_resp);
    check({tag, ".rsp_err"}, rsp_e, v.exp_err);
    check({tag, ".axi_traffic"}, saw_ax, v.exp_axi);
    check({tag, ".beats"}, v.write ? widx : ridx, exp_beats);
    check({tag, ".data_mismatch"}, dmis, 0);
    check({tag, ".last_mismatch"}, lastmis, 0);
    check({tag, ".protocol_viol"}, viol, 0);
    if (v.exp_axi) begin
      check({tag, ".axaddr"}, seen_addr, v.addr);
      check({tag, ".axlen"}, seen_len, v.len);
      check({tag, ".axsize"}, seen_size, 3'd2);
    end
    if (v.exp_lat >= 0) check({tag, ".latency"}, rsp_cyc - acc_cyc, v.exp_lat);
    $display("txn %s: wr=%0d addr=0x%04h len=%0d resp=%0d err=%0d beats=%0d lat=%0d",
             tag, v.write, v.addr, v.len, rsp_r, rsp_e, v.write ? widx : ridx, rsp_cyc - acc_cyc);
  endtask

  vec_t vecs [13];

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wdat_valid = 0; bus.wdat_data = '0; bus.rdat_ready = 0;
    bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 0;
    bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = '0; bus.RRESP = 0; bus.RLAST = 0;
    stall = 0; slv_resp = 0; last_at = 0; dbase = 0; cyc = 0;
    clear_model();

    //              wr  addr      len    st last slv    dbase            err resp  axi lat
    vecs[0]  = '{1, 16'h0010, 8'd3,   0, 3,   2'b00, 32'h0000_00A0,  0, 2'b00, 1, 7};
    vecs[1]  = '{0, 16'h0010, 8'd3,   0, 3,   2'b00, 32'h0000_00A0,  0, 2'b00, 1, 6};
    vecs[2]  = '{1, 16'h0FF8, 8'd3,   0, 3,   2'b00, 32'h0000_00F0,  1, 2'b10, 0, 1};
    vecs[3]  = '{1, 16'h0FF0, 8'd3,   0, 3,   2'b00, 32'h0000_00B0,  0, 2'b00, 1, 7};
    vecs[4]  = '{1, 16'h0012, 8'd0,   0, 0,   2'b00, 32'h0000_00F0,  1, 2'b10, 0, 1};
    vecs[5]  = '{0, 16'h0FFC, 8'd1,   0, 1,   2'b00, 32'h0000_0000,  1, 2'b10, 0, 1};
    vecs[6]  = '{1, 16'h0400, 8'd255, 1, 255, 2'b00, 32'h1000_0000,  0, 2'b00, 1, -1};
    vecs[7]  = '{0, 16'h0400, 8'd255, 1, 255, 2'b00, 32'h1000_0000,  0, 2'b00, 1, -1};
    vecs[8]  = '{0, 16'h0010, 8'd3,   0, 1,   2'b00, 32'h0000_00A0,  1, 2'b00, 1, 4};
    vecs[9]  = '{1, 16'h0020, 8'd1,   0, 1,   2'b10, 32'h0000_00C0,  0, 2'b10, 1, 5};
    vecs[10] = '{0, 16'h0020, 8'd1,   0, 1,   2'b01, 32'h0000_00C0,  0, 2'b01, 1, 4};
    vecs[11] = '{0, 16'h0010, 8'd1,   0, 2,   2'b00, 32'h0000_00A0,  1, 2'b00, 1, 5};
    vecs[12] = '{0, 16'h0400, 8'd3,   0, 3,   2'b11, 32'h1000_0000,  0, 2'b11, 1, 6};

    // reset state
    repeat (2) @(negedge ACLK);
    #1;
    check("reset.cmd_ready", bus.cmd_ready, 0);
    check("reset.valids", {bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY,
                           bus.rsp_valid, bus.wdat_ready, bus.rdat_valid}, 0);
    check("reset.regs", {bus.AWADDR, bus.AWLEN, bus.rsp_resp, bus.rsp_err}, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    step(); step();
    check("reset.cmd_ready_release", bus.cmd_ready, 1);

    for (int i = 0; i < 13; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // reset in the middle of a write burst, right after beat 0 is taken
    stall = 0; slv_resp = 0; dbase = 32'hE0; wn = 4; widx = 0; aw_done = 0;
    bus.cmd_write = 1; bus.cmd_addr = 16'h0040; bus.cmd_len = 8'd3; cmd_pend = 1;
    for (int k = 0; k < 50 && widx < 1; k++) step();
    check("midrst.beat0_taken", widx, 1);
    @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    check("midrst.valids", {bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY,
                            bus.rsp_valid, bus.wdat_ready, bus.rdat_valid, bus.cmd_ready}, 0);
    clear_model();
    @(negedge ACLK);
    ARESET = 1'b0;
    step(); step();
    check("midrst.cmd_ready", bus.cmd_ready, 1);
    $display("txn midrst: reset during write beat 1, released");
    run_txn('{1, 16'h0040, 8'd0, 0, 0, 2'b00, 32'h0000_00D0, 0, 2'b00, 1, 4}, "post_rst_wr");
    run_txn('{0, 16'h0040, 8'd0, 0, 0, 2'b00, 32'h0000_00D0, 0, 2'b00, 1, 3}, "post_rst_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
